// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel debouncer.
//   db_state_e    : per-channel debounce state encoding
//   MS_PER_TICK   : length of one prescaler tick in milliseconds
//   TICKS_PER_SEC : prescaler ticks per second (clock divider base)
//   max_int       : helper used when sizing the per-channel counter
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE0 = 2'b00,
    PEND1   = 2'b01,
    PEND0   = 2'b10,
    STABLE1 = 2'b11
  } db_state_e;

  localparam int MS_PER_TICK   = 1;
  localparam int TICKS_PER_SEC = 1000 / MS_PER_TICK;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounce channel: 2-FF synchronizer, four-state settle FSM, tick
// counter and registered level/edge outputs.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (adds long_o / LONGPRESS_MS).
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   sig_i   : raw asynchronous input
//   tick_i  : one-cycle pulse per millisecond from the shared prescaler
//   sig_o   : debounced level (registered)
//   rise_o  : one-cycle pulse when sig_o goes 0->1
//   fall_o  : one-cycle pulse when sig_o goes 1->0
//   long_o  : one-cycle pulse after LONGPRESS_MS ticks in STABLE1 (optional)
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int CW          = 4
`ifdef DEBOUNCE_LONGPRESS_EN
  ,
  parameter int LONGPRESS_MS = 1000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  input  logic tick_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_LONGPRESS_EN
  ,
  output logic long_o
`endif
);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_MS - 1);
`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [CW-1:0] LP_LAST = CW'(LONGPRESS_MS - 1);
  localparam logic [CW-1:0] LP_MAX  = CW'(LONGPRESS_MS);
`endif

  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            sig_q, sig_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
`ifdef DEBOUNCE_LONGPRESS_EN
  logic            long_q, long_d;
`endif
  logic            s;

  // Next-state logic. A revert (s back to the old level) is checked before
  // the tick so that a revert and a tick in the same cycle resolve as revert.
  always_comb begin
    sync1_d = sig_i;
    sync2_d = sync1_q;
    s       = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
    long_d  = 1'b0;
`endif
    case (state_q)
      STABLE0: begin
        if (s) begin
          state_d = PEND1;
          cnt_d   = '0;
        end
      end
      STABLE1: begin
        if (!s) begin
          state_d = PEND0;
          cnt_d   = '0;
        end
`ifdef DEBOUNCE_LONGPRESS_EN
        // Hold counter saturates at LONGPRESS_MS so each press pulses once.
        else if (tick_i && (cnt_q != LP_MAX)) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LP_LAST) begin
            long_d = 1'b1;
          end
        end
`endif
      end
      PEND1: begin
        if (!s) begin
          state_d = STABLE0;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == DB_LAST) begin
            state_d = STABLE1;
            cnt_d   = '0;
            sig_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PEND0: begin
        if (s) begin
          state_d = STABLE1;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == DB_LAST) begin
            state_d = STABLE0;
            cnt_d   = '0;
            sig_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = STABLE0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STABLE0;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sig_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sig_q   <= sig_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef DEBOUNCE_LONGPRESS_EN
      long_q  <= long_d;
`endif
    end
  end

  assign sig_o  = sig_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`ifdef DEBOUNCE_LONGPRESS_EN
  assign long_o = long_q;
`endif

endmodule

// File: rtl/multi_debounce.sv
// ---------------------------------------------------------------------------
// multi_debounce
// N_CH independent debounce channels sharing one millisecond prescaler.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (adds long_o port).
// Ports:
//   clk    : clock (CLK_FREQ_HZ)
//   rst_n  : synchronous active-low reset
//   sig_i  : raw asynchronous inputs, one bit per channel
//   sig_o  : debounced levels
//   rise_o : one-cycle pulses on debounced 0->1
//   fall_o : one-cycle pulses on debounced 1->0
//   long_o : one-cycle long-press pulses (only with DEBOUNCE_LONGPRESS_EN)
// ---------------------------------------------------------------------------
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_MS  = 10,
  parameter int LONGPRESS_MS = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_i,
  output logic [N_CH-1:0] sig_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
`ifdef DEBOUNCE_LONGPRESS_EN
  ,
  output logic [N_CH-1:0] long_o
`endif
);

  // Parameter sanity checks stop elaboration on illegal configurations.
  if (CLK_FREQ_HZ < 1000) begin : g_bad_clk
    $error("multi_debounce: CLK_FREQ_HZ must be at least 1000");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("multi_debounce: N_CH must be at least 1");
  end
  if (DEBOUNCE_MS < 1) begin : g_bad_db
    $error("multi_debounce: DEBOUNCE_MS must be at least 1");
  end
  if (LONGPRESS_MS < 1) begin : g_bad_lp
    $error("multi_debounce: LONGPRESS_MS must be greater than 0");
  end

  localparam int PRESC_N = CLK_FREQ_HZ / TICKS_PER_SEC;
  localparam int PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_N - 1);

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int CNT_MAX = max_int(DEBOUNCE_MS, LONGPRESS_MS);
`else
  localparam int CNT_MAX = max_int(DEBOUNCE_MS, 1);
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Free-running millisecond prescaler; tick marks its terminal count.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .CW          (CW)
`ifdef DEBOUNCE_LONGPRESS_EN
      ,
      .LONGPRESS_MS(LONGPRESS_MS)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_i (sig_i[i]),
      .tick_i(tick),
      .sig_o (sig_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
`ifdef DEBOUNCE_LONGPRESS_EN
      ,
      .long_o(long_o[i])
`endif
    );
  end

endmodule
